// File: rtl/sram_stream_buffer.sv
// Byte-stream FIFO that parks data in the external SRAM (via the arbiter user
// channel) as a large circular buffer and plays it back in order.
module sram_stream_buffer #(
  parameter int DW         = 8,
  parameter int AW         = 19,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          rd_err,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] data_wr,
  output logic          ena,
  output logic          wea,
  input  logic          busya,
  input  logic          valida,
  input  logic [DW-1:0] data_rd
);

  localparam int SPW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SCW = $clog2(SKID_DEPTH + 1);
  localparam int IFW = $clog2(RD_LAT + 1);
  localparam int OW  = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic           pref_rd_q, pref_rd_d;
  logic           rd_err_q, rd_err_d;
  logic           tag_q [RD_LAT];
  logic [DW-1:0]  skid_mem [SKID_DEPTH];
  logic [SPW-1:0] skid_head_q, skid_head_d;
  logic [SPW-1:0] skid_tail_q, skid_tail_d;
  logic [SCW-1:0] skid_cnt_q, skid_cnt_d;

  logic [IFW-1:0] inflight;
  logic [OW-1:0]  occ;
  logic           full_c;
  logic           rd_eligible;
  logic           wr_grant;
  logic           rd_grant;
  logic           ret_flag;
  logic           skid_push;
  logic           skid_pop;

  function automatic logic [SPW-1:0] skid_inc(input logic [SPW-1:0] p);
    if (p == SPW'(SKID_DEPTH - 1)) begin
      return '0;
    end
    return p + SPW'(1);
  endfunction

  // Outstanding read returns, oldest at the highest index.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IFW'(tag_q[i]);
    end
  end

  // Credit: only issue a read if its return is guaranteed a skid slot.
  always_comb begin
    occ         = OW'(skid_cnt_q) + OW'(inflight);
    full_c      = (level_q == {1'b1, {AW{1'b0}}});
    rd_eligible = (level_q != '0) && !busya && (occ < OW'(SKID_DEPTH));
    s_ready     = !rst && !busya && !full_c && !(rd_eligible && pref_rd_q);
    wr_grant    = s_valid && s_ready;
    rd_grant    = !rst && rd_eligible && !wr_grant;
  end

  always_comb begin
    ena     = wr_grant || rd_grant;
    wea     = wr_grant;
    addra   = '0;
    data_wr = '0;
    if (wr_grant) begin
      addra   = wr_ptr_q;
      data_wr = s_data;
    end else if (rd_grant) begin
      addra = rd_ptr_q;
    end
  end

  assign ret_flag  = tag_q[RD_LAT-1];
  assign skid_push = ret_flag && valida;
  assign m_valid   = !rst && (skid_cnt_q != '0);
  assign m_data    = skid_mem[skid_head_q];
  assign skid_pop  = m_valid && m_ready;
  assign level     = level_q;
  assign full      = full_c;
  assign rd_err    = rd_err_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pref_rd_d   = pref_rd_q;
    rd_err_d    = rd_err_q;
    skid_head_d = skid_head_q;
    skid_tail_d = skid_tail_q;
    skid_cnt_d  = skid_cnt_q;

    if (wr_grant) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      level_d  = level_q + (AW+1)'(1);
    end else if (rd_grant) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d  = level_q - (AW+1)'(1);
    end

    // Alternate service when both sides compete.
    if (wr_grant && rd_eligible) begin
      pref_rd_d = 1'b1;
    end else if (rd_grant && s_valid && !full_c) begin
      pref_rd_d = 1'b0;
    end

    if (ret_flag && !valida) begin
      rd_err_d = 1'b1;
    end

    if (skid_push) begin
      skid_tail_d = skid_inc(skid_tail_q);
    end
    if (skid_pop) begin
      skid_head_d = skid_inc(skid_head_q);
    end
    case ({skid_push, skid_pop})
      2'b10:   skid_cnt_d = skid_cnt_q + SCW'(1);
      2'b01:   skid_cnt_d = skid_cnt_q - SCW'(1);
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pref_rd_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      skid_head_q <= '0;
      skid_tail_q <= '0;
      skid_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pref_rd_q   <= pref_rd_d;
      rd_err_q    <= rd_err_d;
      skid_head_q <= skid_head_d;
      skid_tail_q <= skid_tail_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && skid_push) begin
      skid_mem[skid_tail_q] <= data_rd;
    end
  end

  // Read-tag shift register; a return arriving while in reset is discarded.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_q[gi] <= 1'b0;
        end else begin
          tag_q[gi] <= rd_grant;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_q[gi] <= 1'b0;
        end else begin
          tag_q[gi] <= tag_q[gi-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_stream_buffer.sv
// Directed bench for sram_stream_buffer with a small behavioural SRAM
// (AW=4, one-cycle read return) and an in-order output scoreboard.
module tb_sram_stream_buffer;
  localparam int DW         = 8;
  localparam int AW         = 4;
  localparam int RD_LAT     = 1;
  localparam int SKID_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   level;
  logic          full;
  logic          rd_err;
  logic [AW-1:0] addra;
  logic [DW-1:0] data_wr;
  logic          ena;
  logic          wea;
  logic          busya;
  logic          valida;
  logic [DW-1:0] data_rd;

  sram_stream_buffer #(
    .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .full(full), .rd_err(rd_err),
    .addra(addra), .data_wr(data_wr), .ena(ena), .wea(wea),
    .busya(busya), .valida(valida), .data_rd(data_rd)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM behind the arbiter; drop_rd suppresses a read return.
  logic [DW-1:0] mem [1 << AW];
  logic          sram_v = 1'b0;
  logic [DW-1:0] sram_d = '0;
  logic          drop_rd = 1'b0;
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= data_wr;
    sram_v <= ena && !wea && !drop_rd;
    sram_d <= mem[addra];
  end
  assign valida  = sram_v;
  assign data_rd = sram_d;

  int n_cmp = 0;
  int n_err = 0;
  int rd_grants = 0;
  int n_out = 0;
  bit feed_en = 1'b0;
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] exp_q [$];
  logic          smp_ena, smp_wea, smp_sready, smp_mvalid;
  logic [AW-1:0] smp_addra;
  logic [DW-1:0] smp_data_wr, smp_mdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1ns later, then
  // advance to the next falling edge.
  task automatic tick();
    logic acc, popd;
    logic [DW-1:0] e;
    s_valid = feed_en && (src_q.size() != 0);
    s_data  = s_valid ? src_q[0] : '0;
    #1;
    smp_ena     = ena;
    smp_wea     = wea;
    smp_addra   = addra;
    smp_data_wr = data_wr;
    smp_sready  = s_ready;
    smp_mvalid  = m_valid;
    smp_mdata   = m_data;
    acc  = s_valid && s_ready;
    popd = m_valid && m_ready;
    if (smp_ena && !smp_wea) rd_grants++;
    if (popd) begin
      n_out++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(m_data), 32'(e));
      end
    end
    if (acc) exp_q.push_back(s_data);
    chk("skid_bound", 32'(dut.skid_cnt_q <= SKID_DEPTH), 32'd1);
    @(negedge clk);
    if (acc) void'(src_q.pop_front());
  endtask

  initial begin : main
    logic [AW-1:0] a_addr [9];
    logic          a_ena  [9];
    logic          a_wea  [9];
    logic [DW-1:0] a_wdat [9];
    logic [AW:0]   a_lvl  [9];
    logic [DW-1:0] a_out  [4];
    int out_start;

    a_ena  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    a_wea  = '{1, 1, 0, 1, 0, 1, 0, 0, 0};
    a_addr = '{0, 1, 0, 2, 1, 3, 2, 3, 0};
    a_wdat = '{8'h11, 8'h22, 0, 8'h33, 0, 8'h44, 0, 0, 0};
    a_lvl  = '{1, 2, 1, 2, 1, 2, 1, 0, 0};
    a_out  = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; m_ready = 1'b0; busya = 1'b0; s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(smp_sready), 32'd0);
    chk("rst_ena", 32'(smp_ena), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", 32'(smp_sready), 32'd1);
    chk("idle_ena", 32'(smp_ena), 32'd0);

    // Ordered readback
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    feed_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("ord_ena_c%0d", c), 32'(smp_ena), 32'(a_ena[c]));
      chk($sformatf("ord_wea_c%0d", c), 32'(smp_wea), 32'(a_wea[c]));
      chk($sformatf("ord_addra_c%0d", c), 32'(smp_addra), 32'(a_addr[c]));
      if (a_wea[c]) chk($sformatf("ord_wdat_c%0d", c), 32'(smp_data_wr), 32'(a_wdat[c]));
      chk($sformatf("ord_level_c%0d", c), 32'(level), 32'(a_lvl[c]));
      if (c == 2) chk("ord_held_s_ready", 32'(smp_sready), 32'd0);
    end
    chk("ord_m_valid", 32'(m_valid), 32'd1);
    chk("ord_head", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ord_out%0d", k), 32'(smp_mdata), 32'(a_out[k]));
    end
    chk("ord_drained", 32'(m_valid), 32'd0);
    chk("ord_sb_empty", 32'(exp_q.size()), 32'd0);

    // Contention from a clean state
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 40; i++) src_q.push_back(8'(8'h80 + i));
    for (int c = 0; c < 40; c++) begin
      tick();
      chk($sformatf("cont_ena_c%0d", c), 32'(smp_ena), 32'd1);
      chk($sformatf("cont_wea_c%0d", c), 32'(smp_wea), 32'((c < 2) || (c % 2 == 1)));
    end
    feed_en = 1'b0;
    src_q.delete();
    repeat (10) tick();
    chk("cont_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("cont_level", 32'(level), 32'd0);

    // Full and pointer wrap
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 12; i++) src_q.push_back(8'(i));
    feed_en = 1'b1;
    repeat (40) tick();
    chk("pre_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("pre_level", 32'(level), 32'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 21; i++) src_q.push_back(8'(8'hA0 + i));
    repeat (40) tick();
    chk("full_level", 32'(level), 32'd16);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_s_ready", 32'(smp_sready), 32'd0);
    chk("full_ena", 32'(smp_ena), 32'd0);
    chk("full_held", 32'(src_q.size()), 32'd1);
    chk("full_head", 32'(m_data), 32'hA0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    chk("wrap_rd_ena", 32'(smp_ena), 32'd1);
    chk("wrap_rd_wea", 32'(smp_wea), 32'd0);
    chk("wrap_rd_addr", 32'(smp_addra), 32'd0);
    chk("wrap_not_full", 32'(full), 32'd0);
    tick();
    chk("wrap_wr_ena", 32'(smp_ena), 32'd1);
    chk("wrap_wr_wea", 32'(smp_wea), 32'd1);
    chk("wrap_wr_addr", 32'(smp_addra), 32'd0);
    chk("wrap_wr_data", 32'(smp_data_wr), 32'hB4);
    chk("wrap_level", 32'(level), 32'd16);
    m_ready = 1'b1;
    repeat (60) tick();
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_level_end", 32'(level), 32'd0);

    // Busy stall with both sides pending
    m_ready = 1'b0;
    out_start = n_out;
    src_q = '{8'h51, 8'h52, 8'h53};
    repeat (2) tick();
    for (int i = 4; i <= 8; i++) src_q.push_back(8'(8'h50 + i));
    busya = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("busy_ena_c%0d", c), 32'(smp_ena), 32'd0);
      chk($sformatf("busy_s_ready_c%0d", c), 32'(smp_sready), 32'd0);
    end
    busya = 1'b0;
    repeat (30) tick();
    chk("busy_src_empty", 32'(src_q.size()), 32'd0);
    chk("busy_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_out_count", 32'(n_out - out_start), 32'd8);

    // Output backpressure
    m_ready = 1'b0;
    rd_grants = 0;
    for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h60 + i));
    repeat (30) tick();
    chk("bp_rd_grants", 32'(rd_grants), 32'd4);
    chk("bp_level", 32'(level), 32'd6);
    chk("bp_ena", 32'(smp_ena), 32'd0);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h60);
    m_ready = 1'b1;
    repeat (40) tick();
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_level_end", 32'(level), 32'd0);

    // Missing read return
    m_ready = 1'b0;
    chk("err_clear", 32'(rd_err), 32'd0);
    drop_rd = 1'b1;
    src_q = '{8'h70};
    repeat (3) tick();
    drop_rd = 1'b0;
    chk("err_set", 32'(rd_err), 32'd1);
    chk("err_m_valid", 32'(m_valid), 32'd0);
    chk("err_level", 32'(level), 32'd0);
    exp_q.delete();

    // Reset in the cycle after a read grant
    src_q = '{8'h77};
    tick();
    chk("mid_wr", 32'(smp_wea), 32'd1);
    tick();
    chk("mid_rd_ena", 32'(smp_ena), 32'd1);
    chk("mid_rd_wea", 32'(smp_wea), 32'd0);
    rst = 1'b1;
    src_q = '{8'h78};
    tick();
    chk("mid_rst_ena", 32'(smp_ena), 32'd0);
    chk("mid_rst_s_ready", 32'(smp_sready), 32'd0);
    rst = 1'b0;
    feed_en = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) tick();
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_rd_err", 32'(rd_err), 32'd0);
    chk("mid_ena", 32'(smp_ena), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
